conv_interleaver_ram: RTL and testbench

//  Parametrised Forney convolutional interleaver/deinterleaver for byte/symbol streams.

---
 rtl/conv_interleaver_ram.sv | 145 ++++++++++++++
 tb/tb_conv_interleaver_ram.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_interleaver_ram.sv
// Forney convolutional interleaver/deinterleaver. Each nonzero-delay branch FIFO is a
// circular buffer region inside one shared read-first RAM.
module conv_interleaver_ram #(
  parameter int W     = 8,
  parameter int I     = 12,
  parameter int M     = 17,
  parameter int DEINT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_din,
  input  logic         i_din_valid,
  input  logic         i_din_sync,
  output logic [W-1:0] o_dout,
  output logic         o_dout_valid,
  output logic         o_dout_sync,
  output logic [4:0]   o_branch
);

  localparam int DEPTH = M * I * (I - 1) / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXD  = (I - 1) * M;
  localparam int FW    = $clog2(MAXD + 1);
  localparam int BW    = $clog2(I);
  localparam logic [BW-1:0] LAST_B = BW'(I - 1);

  function automatic int f_delay(input int j);
    return (DEINT != 0) ? (I - 1 - j) * M : j * M;
  endfunction

  // Only one branch has zero delay, so summing all lower branches equals the nonzero sum.
  function automatic int f_base(input int j);
    int s;
    s = 0;
    for (int k = 0; k < j; k++) s += f_delay(k);
    return s;
  endfunction

  logic [FW-1:0] w_delay [I];
  logic [AW-1:0] w_base  [I];

  for (genvar j = 0; j < I; j++) begin : g_branch
    assign w_delay[j] = FW'(f_delay(j));
    assign w_base[j]  = AW'(f_base(j));
  end

  logic [BW-1:0] r_bcnt;
  logic [FW-1:0] r_ptr  [I];
  logic [FW-1:0] r_fill [I];
  logic [W-1:0]  r_mem  [DEPTH];
  logic [W-1:0]  r_dout;
  logic          r_dout_valid;
  logic          r_dout_sync;
  logic [4:0]    r_branch;

  logic [BW-1:0] w_b;
  logic [BW-1:0] w_b_next;
  logic [FW-1:0] w_d;
  logic [FW-1:0] w_ptr;
  logic [FW-1:0] w_fill;
  logic [AW-1:0] w_addr;
  logic          w_nz;
  logic          w_full;
  logic          w_ptr_last;
  logic          w_wr;

  // Branch for the current symbol; a packet-start symbol always lands on branch 0
  always_comb begin
    if (i_din_sync) begin
      w_b = {BW{1'b0}};
    end else begin
      w_b = r_bcnt;
    end
  end

  assign w_b_next   = (w_b == LAST_B) ? {BW{1'b0}} : w_b + BW'(1);
  assign w_d        = w_delay[w_b];
  assign w_ptr      = r_ptr[w_b];
  assign w_fill     = r_fill[w_b];
  assign w_nz       = (w_d != {FW{1'b0}});
  assign w_full     = (w_fill == w_d);
  assign w_ptr_last = (w_ptr == w_d - FW'(1));
  assign w_addr     = w_base[w_b] + AW'(w_ptr);
  assign w_wr       = i_din_valid & w_nz;

  // Commutator position for the next accepted symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt <= {BW{1'b0}};
    end else if (i_din_valid) begin
      r_bcnt <= w_b_next;
    end
  end

  // Per-branch write pointer and saturating fill count; skipped branches are untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < I; j++) begin
        r_ptr[j]  <= {FW{1'b0}};
        r_fill[j] <= {FW{1'b0}};
      end
    end else if (w_wr) begin
      r_ptr[w_b] <= w_ptr_last ? {FW{1'b0}} : w_ptr + FW'(1);
      if (!w_full) begin
        r_fill[w_b] <= w_fill + FW'(1);
      end
    end
  end

  // Shared branch RAM, written after its old word is read out in the same cycle
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_addr] <= i_din;
    end
  end

  // Output stage: bypass for the zero-delay branch, zero mask until the branch has filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= {W{1'b0}};
      r_dout_valid <= 1'b0;
      r_dout_sync  <= 1'b0;
      r_branch     <= 5'd0;
    end else if (i_din_valid) begin
      r_dout_valid <= 1'b1;
      r_dout_sync  <= i_din_sync;
      r_branch     <= 5'(w_b);
      if (!w_nz) begin
        r_dout <= i_din;
      end else if (w_full) begin
        r_dout <= r_mem[w_addr];
      end else begin
        r_dout <= {W{1'b0}};
      end
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_sync  = r_dout_sync;
  assign o_branch     = r_branch;

endmodule

// File: tb/tb_conv_interleaver_ram.sv
// Bench for conv_interleaver_ram: main 12x17 interleaver, interleaver->deinterleaver chain,
// and two corner parameter sets, all compared against per-branch FIFO reference models.
module tb_conv_interleaver_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic m_rst_n, g_rst_n;

  logic [7:0] m_din, m_dout;
  logic       m_v, m_s, m_dv, m_ds;
  logic [4:0] m_br;

  logic [7:0] c_din, i_dout, c_dout;
  logic       c_v, c_s, i_dv, i_ds, c_dv, c_ds;
  logic [4:0] i_br, c_br;

  logic [0:0] a_din, a_dout;
  logic       a_v, a_s, a_dv, a_ds;
  logic [4:0] a_br;

  logic [9:0] b_din, b_dout;
  logic       b_v, b_s, b_dv, b_ds;
  logic [4:0] b_br;

  conv_interleaver_ram #(.W(8), .I(12), .M(17), .DEINT(0)) u_main (
    .clk(clk), .rst_n(m_rst_n), .i_din(m_din), .i_din_valid(m_v), .i_din_sync(m_s),
    .o_dout(m_dout), .o_dout_valid(m_dv), .o_dout_sync(m_ds), .o_branch(m_br));

  conv_interleaver_ram #(.W(8), .I(12), .M(17), .DEINT(0)) u_int (
    .clk(clk), .rst_n(g_rst_n), .i_din(c_din), .i_din_valid(c_v), .i_din_sync(c_s),
    .o_dout(i_dout), .o_dout_valid(i_dv), .o_dout_sync(i_ds), .o_branch(i_br));

  conv_interleaver_ram #(.W(8), .I(12), .M(17), .DEINT(1)) u_deint (
    .clk(clk), .rst_n(g_rst_n), .i_din(i_dout), .i_din_valid(i_dv), .i_din_sync(i_ds),
    .o_dout(c_dout), .o_dout_valid(c_dv), .o_dout_sync(c_ds), .o_branch(c_br));

  conv_interleaver_ram #(.W(1), .I(2), .M(1), .DEINT(1)) u_small (
    .clk(clk), .rst_n(g_rst_n), .i_din(a_din), .i_din_valid(a_v), .i_din_sync(a_s),
    .o_dout(a_dout), .o_dout_valid(a_dv), .o_dout_sync(a_ds), .o_branch(a_br));

  conv_interleaver_ram #(.W(10), .I(32), .M(3), .DEINT(0)) u_wide (
    .clk(clk), .rst_n(g_rst_n), .i_din(b_din), .i_din_valid(b_v), .i_din_sync(b_s),
    .o_dout(b_dout), .o_dout_valid(b_dv), .o_dout_sync(b_ds), .o_branch(b_br));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: commutator plus one FIFO of D_b symbols per branch.
  int mI[3];
  int mM[3];
  int mDe[3];
  int nb[3];
  int hq[3][32][$];

  task automatic model_reset(input int id);
    nb[id] = 0;
    for (int k = 0; k < 32; k++) hq[id][k].delete();
  endtask

  task automatic model_step(input int id, input int d, input bit s, output int od, output int ob);
    int b, dl;
    b = s ? 0 : nb[id];
    nb[id] = (b == mI[id] - 1) ? 0 : b + 1;
    dl = ((mDe[id] != 0) ? (mI[id] - 1 - b) : b) * mM[id];
    hq[id][b].push_back(d);
    if (hq[id][b].size() > dl) od = hq[id][b].pop_front();
    else od = 0;
    ob = b;
  endtask

  // Closed-form interleave transfer function for the n mod 256 stream of the main DUT.
  function automatic int tf_exp(input int n);
    int b, idx;
    b = n % 12;
    idx = n - 12 * (b * 17);
    return (idx < 0) ? 0 : idx % 256;
  endfunction

  int  p_d, p_b, p_tf;
  bit  p_v, p_s, p_tfen;

  task automatic main_check();
    check_eq("m_dout", int'(m_dout), p_d);
    check_eq("m_valid", int'(m_dv), int'(p_v));
    check_eq("m_sync", int'(m_ds), int'(p_s));
    check_eq("m_branch", int'(m_br), p_b);
    if (p_tfen) check_eq("m_transfer", int'(m_dout), p_tf);
  endtask

  task automatic main_cycle(input bit v, input int d, input bit s, input int tf);
    int od, ob;
    @(negedge clk);
    main_check();
    m_v = v;
    m_din = 8'(d);
    m_s = s;
    p_tfen = 1'b0;
    if (v) begin
      model_step(0, d, s, od, ob);
      p_d = od;
      p_b = ob;
      p_s = s;
      p_v = 1'b1;
      if (tf >= 0) begin
        p_tf = tf;
        p_tfen = 1'b1;
      end
    end else begin
      p_v = 1'b0;
    end
  endtask

  task automatic reset_main();
    @(negedge clk);
    main_check();
    m_v = 1'b0;
    m_s = 1'b0;
    #2 m_rst_n = 1'b0;
    #1;
    check_eq("async_dout", int'(m_dout), 0);
    check_eq("async_valid", int'(m_dv), 0);
    check_eq("async_branch", int'(m_br), 0);
    repeat (3) @(negedge clk);
    m_rst_n = 1'b1;
    model_reset(0);
    p_d = 0; p_b = 0; p_s = 1'b0; p_v = 1'b0; p_tfen = 1'b0;
  endtask

  int cp_d[3], cp_b[3];
  bit cp_v[3], cp_s[3];

  task automatic corner_check(input int id, input int dout, input bit dv, input bit ds, input int br);
    check_eq($sformatf("c%0d_dout", id), dout, cp_d[id]);
    check_eq($sformatf("c%0d_valid", id), int'(dv), int'(cp_v[id]));
    check_eq($sformatf("c%0d_sync", id), int'(ds), int'(cp_s[id]));
    check_eq($sformatf("c%0d_branch", id), br, cp_b[id]);
  endtask

  task automatic corner_gen(input int id, input int dmax, output bit v, output int d, output bit s);
    int od, ob;
    v = 1'($urandom_range(0, 1));
    d = $urandom_range(0, dmax);
    s = ($urandom_range(0, 49) == 0);
    if (v) begin
      model_step(id, d, s, od, ob);
      cp_d[id] = od; cp_b[id] = ob; cp_s[id] = s; cp_v[id] = 1'b1;
    end else begin
      cp_v[id] = 1'b0;
    end
  endtask

  int chain_q[$];

  initial begin
    mI  = '{12, 2, 32};
    mM  = '{17, 1, 3};
    mDe = '{0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      cp_d[k] = 0; cp_b[k] = 0; cp_v[k] = 1'b0; cp_s[k] = 1'b0;
    end
    p_d = 0; p_b = 0; p_tf = 0; p_v = 1'b0; p_s = 1'b0; p_tfen = 1'b0;
    m_din = 8'd0; m_v = 1'b0; m_s = 1'b0;
    c_din = 8'd0; c_v = 1'b0; c_s = 1'b0;
    a_din = 1'b0; a_v = 1'b0; a_s = 1'b0;
    b_din = 10'd0; b_v = 1'b0; b_s = 1'b0;
    m_rst_n = 1'b1;
    g_rst_n = 1'b1;
    #2;
    m_rst_n = 1'b0;
    g_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", int'(m_dout), 0);
    check_eq("rst_valid", int'(m_dv), 0);
    check_eq("rst_sync", int'(m_ds), 0);
    check_eq("rst_branch", int'(m_br), 0);
    m_rst_n = 1'b1;
    g_rst_n = 1'b1;

    fork
      begin : main_seq
        int n;
        // Continuous stream n mod 256, sync only at n=0.
        for (int k = 0; k < 2300; k++) main_cycle(1'b1, k % 256, k == 0, tf_exp(k));
        // Same stream with 50% valid density.
        reset_main();
        n = 0;
        for (int k = 0; k < 3000; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            main_cycle(1'b1, n % 256, n == 0, tf_exp(n));
            n++;
          end else begin
            main_cycle(1'b0, 0, 1'b0, -1);
          end
        end
        // Random data, mid-cycle resync at n=1005, reset pulse at n=3000.
        reset_main();
        for (int k = 0; k < 5000; k++) begin
          if (k == 3000) reset_main();
          main_cycle(1'b1, $urandom_range(0, 255), (k == 0) || (k == 1005), -1);
        end
        @(negedge clk);
        main_check();
        m_v = 1'b0;
      end
      begin : chain_seq
        int x, j, e;
        for (int k = 0; k < 22250; k++) begin
          @(negedge clk);
          if (k >= 2) begin
            j = k - 2;
            e = (j >= 2244) ? chain_q[j - 2244] : 0;
            check_eq("chain_dout", int'(c_dout), e);
            check_eq("chain_valid", int'(c_dv), 1);
            check_eq("chain_sync", int'(c_ds), (j == 0) ? 1 : 0);
          end
          x = $urandom_range(0, 255);
          chain_q.push_back(x);
          c_din = 8'(x);
          c_v = 1'b1;
          c_s = (k == 0);
        end
        @(negedge clk);
        c_v = 1'b0;
      end
      begin : corner_seq
        bit v, s;
        int d;
        for (int k = 0; k < 5000; k++) begin
          @(negedge clk);
          corner_check(1, int'(a_dout), a_dv, a_ds, int'(a_br));
          corner_check(2, int'(b_dout), b_dv, b_ds, int'(b_br));
          corner_gen(1, 1, v, d, s);
          a_v = v; a_din = 1'(d); a_s = s;
          corner_gen(2, 1023, v, d, s);
          b_v = v; b_din = 10'(d); b_s = s;
        end
        @(negedge clk);
        a_v = 1'b0;
        b_v = 1'b0;
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
